// File: rtl/pixel_hit_collector_pkg.sv
// rtl/pixel_hit_collector_pkg.sv - shared widths, event tags and word layout for the pixel hit collector
package pixel_readout_pkg;

  localparam int ADDR_W = 15;
  localparam int TS_W   = 15;
  localparam int EVT_W  = 32;
  localparam int CNT_W  = 16;

  localparam logic [1:0] TAG_UP  = 2'b00;
  localparam logic [1:0] TAG_DN  = 2'b01;
  localparam logic [1:0] TAG_OVF = 2'b10;

  typedef struct packed {
    logic [1:0]        tag;
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
  } evt_word_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_hit_collector_if.sv
// rtl/pixel_hit_collector_if.sv - hit strobes in from the readout block, event stream out to downstream
interface pixel_hit_collector_if;

  logic                              up_valid_i;
  logic [pixel_readout_pkg::ADDR_W-1:0] up_addr_i;
  logic                              down_valid_i;
  logic [pixel_readout_pkg::ADDR_W-1:0] down_addr_i;
  logic                              evt_valid_o;
  logic [pixel_readout_pkg::EVT_W-1:0]  evt_data_o;
  logic                              evt_ready_i;

  modport slave (
    input  up_valid_i, up_addr_i, down_valid_i, down_addr_i, evt_ready_i,
    output evt_valid_o, evt_data_o
  );

  modport master (
    output up_valid_i, up_addr_i, down_valid_i, down_addr_i, evt_ready_i,
    input  evt_valid_o, evt_data_o
  );

endinterface

// File: rtl/pixel_evt_fifo_3w1r.sv
// rtl/pixel_evt_fifo_3w1r.sv - first-word-fall-through FIFO taking up to three ordered writes and one read per cycle
module pixel_evt_fifo_3w1r #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               wr_cnt,
  input  logic [2:0][W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // The writer never offers more words than free slots, so no full check here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + (AW+1)'(wr_cnt) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < wr_cnt) begin
        mem[wr_ptr + AW'(i)] <= wr_data[i];
      end
    end
  end

  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rd_ptr] : '0;
  assign level   = count;

endmodule

// File: rtl/pixel_hit_collector.sv
// rtl/pixel_hit_collector.sv - tags up/down hits with half and timestamp, merges them with overflow markers into one event stream
module pixel_hit_collector
  import pixel_readout_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clock,
  input  logic                          sys_resetn,
  input  logic                          readout_en_i,
  input  logic                          clr_stats_i,
  pixel_hit_collector_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]              drop_total_o
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [LW:0] ONE = (LW+1)'(1);

  logic [TS_W-1:0]    ts;
  logic               mk_pend;
  logic [CNT_W-1:0]   mk_cnt;
  logic [CNT_W-1:0]   drop_total;
  logic [LW:0]        level;
  logic [LW:0]        rem;
  logic               up_c, dn_c;
  logic               mk_wr, up_wr, dn_wr;
  logic [1:0]         n_drop;
  logic [1:0]         wr_cnt;
  logic [2:0][EVT_W-1:0] wr_data;
  logic               head_valid;
  logic [EVT_W-1:0]   head;
  logic               pop;
  evt_word_t          up_word, dn_word;
  logic [EVT_W-1:0]   mk_word;

  assign up_c = readout_en_i & bus.up_valid_i;
  assign dn_c = readout_en_i & bus.down_valid_i;

  always_comb begin
    up_word = '{tag: TAG_UP, ts: ts, addr: bus.up_addr_i};
    dn_word = '{tag: TAG_DN, ts: ts, addr: bus.down_addr_i};
    mk_word = {TAG_OVF, 14'd0, mk_cnt};
  end

  // Free slots are judged on start-of-cycle occupancy; a same-cycle pop does not help.
  always_comb begin
    rem     = (LW+1)'(FIFO_DEPTH) - level;
    wr_cnt  = '0;
    wr_data = '0;
    mk_wr   = 1'b0;
    up_wr   = 1'b0;
    dn_wr   = 1'b0;
    if (mk_pend && rem != '0) begin
      mk_wr           = 1'b1;
      wr_data[wr_cnt] = mk_word;
      wr_cnt          = wr_cnt + 2'd1;
      rem             = rem - ONE;
    end
    if (up_c && rem != '0) begin
      up_wr           = 1'b1;
      wr_data[wr_cnt] = up_word;
      wr_cnt          = wr_cnt + 2'd1;
      rem             = rem - ONE;
    end
    if (dn_c && rem != '0) begin
      dn_wr           = 1'b1;
      wr_data[wr_cnt] = dn_word;
      wr_cnt          = wr_cnt + 2'd1;
      rem             = rem - ONE;
    end
    n_drop = 2'(up_c & ~up_wr) + 2'(dn_c & ~dn_wr);
  end

  // A marker written this cycle carries the old count; drops in the same cycle start a fresh one.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      ts         <= '0;
      mk_pend    <= 1'b0;
      mk_cnt     <= '0;
      drop_total <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (mk_wr) begin
        mk_cnt  <= sat_add('0, n_drop);
        mk_pend <= (n_drop != 2'd0);
      end else begin
        mk_cnt  <= sat_add(mk_cnt, n_drop);
        mk_pend <= mk_pend | (n_drop != 2'd0);
      end
      drop_total <= sat_add(clr_stats_i ? '0 : drop_total, n_drop);
    end
  end

  assign pop = head_valid & bus.evt_ready_i;

  pixel_evt_fifo_3w1r #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (sys_clock),
    .rst_n   (sys_resetn),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .valid   (head_valid),
    .level   (level)
  );

  assign bus.evt_valid_o = head_valid;
  assign bus.evt_data_o  = head;
  assign fifo_level_o    = level;
  assign drop_total_o    = drop_total;

endmodule
